iic_fifo_lvl: RTL and testbench

//  Next-generation ring-buffer FIFO with level reporting. Uses the full 2^FIFO_SIZE depth
//  via an occupancy counter, and adds programmable almost-full/almost-empty flags, sticky

---
 rtl/iic_fifo_lvl_if.sv | 61 ++++++
 rtl/iic_fifo_lvl.sv | 132 +++++++++++++
 tb/tb_iic_fifo_lvl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iic_fifo_lvl_if.sv
// Producer/consumer/status bundle for the level-reporting FIFO.
// slave = FIFO side, master = environment side.
interface iic_fifo_lvl_if #(
  parameter int WIDTH     = 16,
  parameter int FIFO_SIZE = 5
);
  logic [WIDTH-1:0]   fifo_indata_i;
  logic               fifo_indata_rdy_i;
  logic               fifo_indata_ack_o;
  logic [WIDTH-1:0]   fifo_outdata_o;
  logic               fifo_outdata_rd_i;
  logic               fifo_full_o;
  logic               fifo_empty_o;
  logic [FIFO_SIZE:0] fifo_level_o;
  logic [FIFO_SIZE:0] afull_thr_i;
  logic [FIFO_SIZE:0] aempty_thr_i;
  logic               fifo_afull_o;
  logic               fifo_aempty_o;
  logic               fifo_ovf_o;
  logic               fifo_udf_o;
  logic               flag_clr_i;
  logic               tst_fifo_loop_i;

  modport slave (
    input  fifo_indata_i,
    input  fifo_indata_rdy_i,
    output fifo_indata_ack_o,
    output fifo_outdata_o,
    input  fifo_outdata_rd_i,
    output fifo_full_o,
    output fifo_empty_o,
    output fifo_level_o,
    input  afull_thr_i,
    input  aempty_thr_i,
    output fifo_afull_o,
    output fifo_aempty_o,
    output fifo_ovf_o,
    output fifo_udf_o,
    input  flag_clr_i,
    input  tst_fifo_loop_i
  );

  modport master (
    output fifo_indata_i,
    output fifo_indata_rdy_i,
    input  fifo_indata_ack_o,
    input  fifo_outdata_o,
    output fifo_outdata_rd_i,
    input  fifo_full_o,
    input  fifo_empty_o,
    input  fifo_level_o,
    output afull_thr_i,
    output aempty_thr_i,
    input  fifo_afull_o,
    input  fifo_aempty_o,
    input  fifo_ovf_o,
    input  fifo_udf_o,
    output flag_clr_i,
    output tst_fifo_loop_i
  );
endinterface

// File: rtl/iic_fifo_lvl.sv
// Ring-buffer FIFO with occupancy counter, level flags,
// sticky error flags, 4-phase producer and loop test mode.
module iic_fifo_lvl #(
  parameter int WIDTH      = 16,
  parameter int FIFO_SIZE  = 5,
  parameter int FIFO_ASYNC = 1,
  parameter logic [WIDTH-1:0] RESET_VAL =
    {1'b1, {(WIDTH-1){1'b0}}}
) (
  input logic clk_i,
  input logic rst_i,
  iic_fifo_lvl_if.slave bus
);

  localparam int DEPTH = 1 << FIFO_SIZE;
  localparam logic [FIFO_SIZE:0] LVL_MAX =
    (FIFO_SIZE+1)'(DEPTH);
  localparam logic [FIFO_SIZE:0] LVL_ONE =
    (FIFO_SIZE+1)'(1);
  localparam logic [FIFO_SIZE-1:0] PTR_ONE =
    FIFO_SIZE'(1);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_SIZE-1:0] wr_ptr;
  logic [FIFO_SIZE-1:0] rd_ptr;
  logic [FIFO_SIZE:0]   level;
  logic [WIDTH-1:0]     hold;
  logic                 ack;
  logic                 ovf;
  logic                 udf;

  logic             rdy_s;
  logic [WIDTH-1:0] data_s;

  if (FIFO_ASYNC != 0) begin : g_sync
    logic             rdy_q1;
    logic             rdy_q2;
    logic [WIDTH-1:0] dat_q1;
    logic [WIDTH-1:0] dat_q2;

    // two-stage synchroniser for request and data
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rdy_q1 <= 1'b0;
        rdy_q2 <= 1'b0;
        dat_q1 <= '0;
        dat_q2 <= '0;
      end else begin
        rdy_q1 <= bus.fifo_indata_rdy_i;
        rdy_q2 <= rdy_q1;
        dat_q1 <= bus.fifo_indata_i;
        dat_q2 <= dat_q1;
      end
    end

    assign rdy_s  = rdy_q2;
    assign data_s = dat_q2;
  end else begin : g_direct
    assign rdy_s  = bus.fifo_indata_rdy_i;
    assign data_s = bus.fifo_indata_i;
  end

  logic full;
  logic empty;
  logic loop;
  logic req;
  logic wr_en;
  logic ovf_set;
  logic rd_en;
  logic udf_set;
  logic loop_wr;
  logic push;

  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign loop    = bus.tst_fifo_loop_i;
  assign req     = rdy_s & ~ack & ~loop;
  assign wr_en   = req & ~full;
  assign ovf_set = req & full;
  assign rd_en   = bus.fifo_outdata_rd_i & ~empty;
  assign udf_set = bus.fifo_outdata_rd_i & empty;
  assign loop_wr = loop & rd_en;
  assign push    = wr_en | loop_wr;

  // storage: producer datum or recirculated head
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem[wr_ptr] <= loop_wr ? mem[rd_ptr] : data_s;
    end
  end

  // pointers, level, handshake, hold and sticky flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ack    <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      hold   <= RESET_VAL;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold   <= mem[rd_ptr];
      end
      unique case (1'b1)
        push & ~rd_en: level <= level + LVL_ONE;
        rd_en & ~push: level <= level - LVL_ONE;
        default:       level <= level;
      endcase
      if (!rdy_s)     ack <= 1'b0;
      else if (wr_en) ack <= 1'b1;
      if (ovf_set)              ovf <= 1'b1;
      else if (bus.flag_clr_i)  ovf <= 1'b0;
      if (udf_set)              udf <= 1'b1;
      else if (bus.flag_clr_i)  udf <= 1'b0;
    end
  end

  assign bus.fifo_indata_ack_o = ack;
  assign bus.fifo_outdata_o    = empty ? hold : mem[rd_ptr];
  assign bus.fifo_full_o       = full;
  assign bus.fifo_empty_o      = empty;
  assign bus.fifo_level_o      = level;
  assign bus.fifo_afull_o      = (level >= bus.afull_thr_i);
  assign bus.fifo_aempty_o     = (level <= bus.aempty_thr_i);
  assign bus.fifo_ovf_o        = ovf;
  assign bus.fifo_udf_o        = udf;

endmodule

// File: tb/tb_iic_fifo_lvl.sv
// Directed bench for iic_fifo_lvl (WIDTH=16, FIFO_SIZE=5,
// FIFO_ASYNC=1).
module tb_iic_fifo_lvl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  iic_fifo_lvl_if #(.WIDTH(16), .FIFO_SIZE(5)) bus ();

  iic_fifo_lvl #(
    .WIDTH(16), .FIFO_SIZE(5), .FIFO_ASYNC(1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic pop();
    bus.fifo_outdata_rd_i = 1'b1;
    tick();
    bus.fifo_outdata_rd_i = 1'b0;
  endtask

  task automatic clr();
    bus.flag_clr_i = 1'b1;
    tick();
    bus.flag_clr_i = 1'b0;
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n;
    n = 0;
    while (bus.fifo_indata_ack_o !== v && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.fifo_indata_ack_o), 32'(v));
  endtask

  task automatic push(input logic [15:0] d);
    bus.fifo_indata_i     = d;
    bus.fifo_indata_rdy_i = 1'b1;
    wait_ack(1'b1, "push_ack");
    bus.fifo_indata_rdy_i = 1'b0;
    wait_ack(1'b0, "push_rel");
  endtask

  initial begin
    bus.fifo_indata_i     = '0;
    bus.fifo_indata_rdy_i = 1'b0;
    bus.fifo_outdata_rd_i = 1'b0;
    bus.afull_thr_i       = 6'd30;
    bus.aempty_thr_i      = 6'd2;
    bus.flag_clr_i        = 1'b0;
    bus.tst_fifo_loop_i   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_level", 32'(bus.fifo_level_o), 0);
    chk("rst_empty", 32'(bus.fifo_empty_o), 1);
    chk("rst_full", 32'(bus.fifo_full_o), 0);
    chk("rst_ack", 32'(bus.fifo_indata_ack_o), 0);
    chk("rst_out", 32'(bus.fifo_outdata_o), 32'h8000);
    chk("rst_ovf", 32'(bus.fifo_ovf_o), 0);
    chk("rst_udf", 32'(bus.fifo_udf_o), 0);
    chk("rst_aempty", 32'(bus.fifo_aempty_o), 1);
    chk("rst_afull", 32'(bus.fifo_afull_o), 0);

    // three-edge ack latency through synchroniser
    bus.fifo_indata_i     = 16'h1234;
    bus.fifo_indata_rdy_i = 1'b1;
    tick();
    chk("lat_e1", 32'(bus.fifo_indata_ack_o), 0);
    tick();
    chk("lat_e2", 32'(bus.fifo_indata_ack_o), 0);
    tick();
    chk("lat_e3", 32'(bus.fifo_indata_ack_o), 1);
    chk("lat_lvl", 32'(bus.fifo_level_o), 1);
    chk("lat_out", 32'(bus.fifo_outdata_o), 32'h1234);
    bus.fifo_indata_rdy_i = 1'b0;
    tick();
    tick();
    chk("rel_e2", 32'(bus.fifo_indata_ack_o), 1);
    tick();
    chk("rel_e3", 32'(bus.fifo_indata_ack_o), 0);
    chk("one_wr", 32'(bus.fifo_level_o), 1);

    // pop to empty, hold register, underflow
    pop();
    chk("hold1", 32'(bus.fifo_outdata_o), 32'h1234);
    chk("hold1_e", 32'(bus.fifo_empty_o), 1);
    chk("no_udf", 32'(bus.fifo_udf_o), 0);
    push(16'hA5A5);
    chk("a5_head", 32'(bus.fifo_outdata_o), 32'hA5A5);
    pop();
    chk("a5_hold", 32'(bus.fifo_outdata_o), 32'hA5A5);
    pop();
    chk("udf_set", 32'(bus.fifo_udf_o), 1);
    chk("udf_lvl", 32'(bus.fifo_level_o), 0);
    chk("udf_hold", 32'(bus.fifo_outdata_o), 32'hA5A5);
    clr();
    chk("udf_clr", 32'(bus.fifo_udf_o), 0);

    // fill to full with level flags
    for (int i = 0; i < 32; i++) begin
      push(16'(16'h0100 + i));
      chk("fill_lvl", 32'(bus.fifo_level_o), 32'(i + 1));
      if (i == 1)
        chk("ae_at2", 32'(bus.fifo_aempty_o), 1);
      if (i == 2)
        chk("ae_at3", 32'(bus.fifo_aempty_o), 0);
      if (i == 28)
        chk("af_at29", 32'(bus.fifo_afull_o), 0);
      if (i == 29)
        chk("af_at30", 32'(bus.fifo_afull_o), 1);
    end
    chk("full", 32'(bus.fifo_full_o), 1);
    chk("full_lvl", 32'(bus.fifo_level_o), 32);
    chk("full_head", 32'(bus.fifo_outdata_o), 32'h0100);

    // overflow then pending write after a pop
    bus.fifo_indata_i     = 16'hDEAD;
    bus.fifo_indata_rdy_i = 1'b1;
    repeat (5) tick();
    chk("ovf_ack", 32'(bus.fifo_indata_ack_o), 0);
    chk("ovf_set", 32'(bus.fifo_ovf_o), 1);
    chk("ovf_lvl", 32'(bus.fifo_level_o), 32);
    pop();
    chk("ovf_pop_lvl", 32'(bus.fifo_level_o), 31);
    wait_ack(1'b1, "ovf_retry");
    chk("retry_lvl", 32'(bus.fifo_level_o), 32);
    chk("retry_full", 32'(bus.fifo_full_o), 1);
    bus.fifo_indata_rdy_i = 1'b0;
    wait_ack(1'b0, "retry_rel");
    clr();
    chk("ovf_clr", 32'(bus.fifo_ovf_o), 0);

    // drain to level 2 checking thresholds
    for (int j = 0; j < 30; j++) begin
      pop();
      if (j == 1)
        chk("af_d30", 32'(bus.fifo_afull_o), 1);
      if (j == 2)
        chk("af_d29", 32'(bus.fifo_afull_o), 0);
      if (j == 28)
        chk("ae_d3", 32'(bus.fifo_aempty_o), 0);
    end
    chk("d_lvl2", 32'(bus.fifo_level_o), 2);
    chk("ae_d2", 32'(bus.fifo_aempty_o), 1);
    chk("d_head", 32'(bus.fifo_outdata_o), 32'h011F);

    // simultaneous write and pop keeps level
    bus.fifo_indata_i     = 16'h0BEE;
    bus.fifo_indata_rdy_i = 1'b1;
    tick();
    tick();
    bus.fifo_outdata_rd_i = 1'b1;
    tick();
    bus.fifo_outdata_rd_i = 1'b0;
    chk("rw_ack", 32'(bus.fifo_indata_ack_o), 1);
    chk("rw_lvl", 32'(bus.fifo_level_o), 2);
    chk("rw_head", 32'(bus.fifo_outdata_o), 32'hDEAD);
    bus.fifo_indata_rdy_i = 1'b0;
    wait_ack(1'b0, "rw_rel");
    pop();
    chk("rw_head2", 32'(bus.fifo_outdata_o), 32'h0BEE);
    pop();
    chk("rw_empty", 32'(bus.fifo_empty_o), 1);
    chk("rw_hold", 32'(bus.fifo_outdata_o), 32'h0BEE);

    // set beats clear in the same cycle
    bus.flag_clr_i = 1'b1;
    pop();
    bus.flag_clr_i = 1'b0;
    chk("set_wins", 32'(bus.fifo_udf_o), 1);
    clr();
    chk("udf_clr2", 32'(bus.fifo_udf_o), 0);

    // loop mode recirculation
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    bus.tst_fifo_loop_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("loop_out", 32'(bus.fifo_outdata_o), 32'(k % 3 + 1));
      pop();
      chk("loop_lvl", 32'(bus.fifo_level_o), 3);
    end
    bus.fifo_indata_i     = 16'h0077;
    bus.fifo_indata_rdy_i = 1'b1;
    repeat (4) tick();
    chk("loop_noack", 32'(bus.fifo_indata_ack_o), 0);
    chk("loop_noovf", 32'(bus.fifo_ovf_o), 0);
    chk("loop_nowr", 32'(bus.fifo_level_o), 3);
    bus.fifo_indata_rdy_i = 1'b0;
    repeat (3) tick();
    bus.tst_fifo_loop_i = 1'b0;
    chk("loop_exit", 32'(bus.fifo_level_o), 3);

    // reset during a pending handshake at level 5
    push(16'h0004);
    push(16'h0005);
    chk("pre_rst_lvl", 32'(bus.fifo_level_o), 5);
    bus.fifo_indata_i     = 16'h0055;
    bus.fifo_indata_rdy_i = 1'b1;
    pop();
    pop();
    pop();
    pop();
    pop();
    bus.fifo_indata_rdy_i = 1'b0;
    chk("pend_lvl", 32'(bus.fifo_level_o), 1);
    chk("pend_ack", 32'(bus.fifo_indata_ack_o), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_lvl", 32'(bus.fifo_level_o), 0);
    chk("mr_ack", 32'(bus.fifo_indata_ack_o), 0);
    chk("mr_ovf", 32'(bus.fifo_ovf_o), 0);
    chk("mr_udf", 32'(bus.fifo_udf_o), 0);
    chk("mr_out", 32'(bus.fifo_outdata_o), 32'h8000);
    repeat (3) tick();
    chk("mr_quiet", 32'(bus.fifo_level_o), 0);
    push(16'h4242);
    chk("post_lvl", 32'(bus.fifo_level_o), 1);
    chk("post_out", 32'(bus.fifo_outdata_o), 32'h4242);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
